// File: rtl/hr_rate_monitor.sv
// Heart-rate monitor: range-checks bpm estimates, averages the last AVG_DEPTH accepted
// samples and classifies the average with hysteresis/confirmation. Option: HR_MON_REJECT_CNT_EN.
module hr_rate_monitor #(
   parameter int AVG_DEPTH   = 4,
   parameter int BRADY_LIMIT = 60,
   parameter int TACHY_LIMIT = 100,
   parameter int HYST        = 5,
   parameter int CONFIRM     = 3,
   parameter int MIN_BPM     = 30,
   parameter int MAX_BPM     = 220
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bpm_in,
   input  logic        bpm_valid,
   output logic [7:0]  avg_bpm,
   output logic        avg_valid,
   input  logic        avg_ready,
   output logic [1:0]  hr_class,
   output logic        alarm,
   output logic        overrun,
   output logic [7:0]  reject_cnt
);

   typedef enum logic [1:0] {
      CLS_NORMAL  = 2'b00,
      CLS_BRADY   = 2'b01,
      CLS_TACHY   = 2'b10,
      CLS_UNKNOWN = 2'b11
   } cls_t;

   localparam int SH     = $clog2(AVG_DEPTH);
   localparam int SUM_W  = 8 + SH;
   localparam int FILL_W = SH + 1;
   localparam int CNT_W  = $clog2(CONFIRM + 1);

   localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(AVG_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_DONE   = CNT_W'(CONFIRM);
   localparam logic [7:0]        BRADY_LO   = 8'(BRADY_LIMIT);
   localparam logic [7:0]        TACHY_HI   = 8'(TACHY_LIMIT);
   localparam logic [7:0]        BRADY_EXIT = 8'(BRADY_LIMIT + HYST);
   localparam logic [7:0]        TACHY_EXIT = 8'(TACHY_LIMIT - HYST);

   // ---------------- stage 0: sample capture and acceptance ----------------
   logic       acc_d;
   logic [7:0] val_d;
   logic       s0_acc;
   logic [7:0] s0_val;

`ifdef HR_MON_REJECT_CNT_EN
   localparam logic [31:0] MIN_W = 32'(MIN_BPM);
   localparam logic [31:0] MAX_W = 32'(MAX_BPM);
   logic rej_d;
   logic s0_rej;

   // The full 32-bit value is range-checked before anything is narrowed.
   always_comb begin
      acc_d = bpm_valid && (bpm_in >= MIN_W) && (bpm_in <= MAX_W);
      rej_d = bpm_valid && !acc_d;
      val_d = bpm_in[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s0_rej     <= 1'b0;
         reject_cnt <= '0;
      end else begin
         s0_rej <= rej_d;
         if (s0_rej && reject_cnt != 8'hFF)
            reject_cnt <= reject_cnt + 8'd1;
      end
   end
`else
   always_comb begin
      acc_d = bpm_valid;
      val_d = (bpm_in > 32'd255) ? 8'hFF : bpm_in[7:0];
   end

   assign reject_cnt = '0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s0_acc <= 1'b0;
         s0_val <= '0;
      end else begin
         s0_acc <= acc_d;
         s0_val <= val_d;
      end
   end

   // ---------------- stage 1: ring buffer and running sum ----------------
   logic [7:0]        ring_q [AVG_DEPTH];
   logic [SH-1:0]     ptr_q;
   logic [SUM_W-1:0]  sum_q;
   logic [FILL_W-1:0] fill_q;
   logic [FILL_W-1:0] fill_nx;
   logic              s1_load;

   assign fill_nx = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

   // NOTE: the buffer is reset explicitly so history cannot leak across a reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= '0;
         ptr_q   <= '0;
         sum_q   <= '0;
         fill_q  <= '0;
         s1_load <= 1'b0;
      end else begin
         s1_load <= s0_acc && (fill_nx == FILL_FULL);
         if (s0_acc) begin
            ring_q[ptr_q] <= s0_val;
            sum_q         <= sum_q + SUM_W'(s0_val) - SUM_W'(ring_q[ptr_q]);
            ptr_q         <= ptr_q + SH'(1);
            fill_q        <= fill_nx;
         end
      end
   end

   // ---------------- stage 2: classification and output ----------------
   logic [7:0]       avg;
   cls_t             state_q, state_d, raw, cand, prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

   assign avg = sum_q[SUM_W-1:SH];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cnt_inc = '0;
      raw     = CLS_NORMAL;
      if (avg < BRADY_LO)
         raw = CLS_BRADY;
      else if (avg > TACHY_HI)
         raw = CLS_TACHY;

      // Leaving an alarm state needs the average to clear the limit by HYST.
      cand = raw;
      if (state_q == CLS_BRADY && avg < BRADY_EXIT) cand = CLS_BRADY;
      if (state_q == CLS_TACHY && avg > TACHY_EXIT) cand = CLS_TACHY;
      prev_d = cand;

      if (state_q == CLS_UNKNOWN) begin
         state_d = raw;
         cnt_d   = '0;
      end else if (cand == state_q) begin
         cnt_d = '0;
      end else begin
         cnt_inc = (cand == prev_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
         if (cnt_inc == CNT_DONE) begin
            state_d = cand;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= CLS_UNKNOWN;
         prev_q    <= CLS_NORMAL;
         cnt_q     <= '0;
         avg_bpm   <= '0;
         avg_valid <= 1'b0;
         alarm     <= 1'b0;
         overrun   <= 1'b0;
      end else if (s1_load) begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         avg_bpm   <= avg;
         avg_valid <= 1'b1;
         alarm     <= (state_d == CLS_BRADY) || (state_d == CLS_TACHY);
         if (avg_valid && !avg_ready) overrun <= 1'b1;
      end else if (avg_valid && avg_ready) begin
         avg_valid <= 1'b0;
      end
   end

   assign hr_class = state_q;

endmodule

// File: tb/tb_hr_rate_monitor.sv
// Bench for hr_rate_monitor: directed plan scenarios then randomized traffic, all checked
// every cycle against a queue-based reference model. Honours HR_MON_REJECT_CNT_EN.
module tb_hr_rate_monitor;

   localparam int DEPTH       = 4;
   localparam int BRADY_LIMIT = 60;
   localparam int TACHY_LIMIT = 100;
   localparam int HYST        = 5;
   localparam int CONFIRM     = 3;
   localparam int MIN_BPM     = 30;
   localparam int MAX_BPM     = 220;
   localparam int C_NORMAL = 0, C_BRADY = 1, C_TACHY = 2, C_UNKNOWN = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bpm_in;
   logic        bpm_valid;
   logic [7:0]  avg_bpm;
   logic        avg_valid;
   logic        avg_ready;
   logic [1:0]  hr_class;
   logic        alarm;
   logic        overrun;
   logic [7:0]  reject_cnt;

   always #5 clk = ~clk;

   hr_rate_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .bpm_in     (bpm_in),
      .bpm_valid  (bpm_valid),
      .avg_bpm    (avg_bpm),
      .avg_valid  (avg_valid),
      .avg_ready  (avg_ready),
      .hr_class   (hr_class),
      .alarm      (alarm),
      .overrun    (overrun),
      .reject_cnt (reject_cnt)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: history queue, class state, a two-deep result delay line.
   int hist[$];
   int n_acc, m_cls, m_prev, m_run;
   bit p1_has, p2_has, rej1;
   int p1_avg, p1_cls, p2_avg, p2_cls;
   int e_avg, e_cls, e_rej;
   bit e_valid, e_alarm, e_ovr;

   function automatic int raw_class(input int a);
      if (a < BRADY_LIMIT) return C_BRADY;
      if (a > TACHY_LIMIT) return C_TACHY;
      return C_NORMAL;
   endfunction

   task automatic model_reset();
      hist.delete();
      n_acc = 0; m_cls = C_UNKNOWN; m_prev = C_NORMAL; m_run = 0;
      p1_has = 0; p2_has = 0; rej1 = 0;
      p1_avg = 0; p1_cls = 0; p2_avg = 0; p2_cls = 0;
      e_avg = 0; e_cls = C_UNKNOWN; e_rej = 0;
      e_valid = 0; e_alarm = 0; e_ovr = 0;
   endtask

   task automatic model_sample(input int val, output bit has, output int a, output int cls);
      int s, raw, cand;
      hist.push_back(val);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      n_acc++;
      has = (n_acc >= DEPTH);
      a = 0; cls = m_cls;
      if (!has) return;
      s = 0;
      foreach (hist[i]) s += hist[i];
      a   = s / DEPTH;
      raw = raw_class(a);
      if (m_cls == C_UNKNOWN) begin
         m_cls = raw; m_run = 0; m_prev = raw;
      end else begin
         cand = raw;
         if (m_cls == C_BRADY && a < BRADY_LIMIT + HYST) cand = C_BRADY;
         if (m_cls == C_TACHY && a > TACHY_LIMIT - HYST) cand = C_TACHY;
         if (cand == m_cls) m_run = 0;
         else begin
            m_run = (cand == m_prev) ? m_run + 1 : 1;
            if (m_run >= CONFIRM) begin m_cls = cand; m_run = 0; end
         end
         m_prev = cand;
      end
      cls = m_cls;
   endtask

   // Advance the model by one rising edge with the given inputs.
   task automatic model_edge(input logic r, input logic v, input logic [31:0] d, input logic rdy);
      bit acc, rej;
      int val;
      if (!r) begin
         model_reset();
         return;
      end
      if (p2_has) begin
         if (e_valid && !rdy) e_ovr = 1;
         e_valid = 1; e_avg = p2_avg; e_cls = p2_cls;
         e_alarm = (p2_cls == C_BRADY) || (p2_cls == C_TACHY);
      end else if (e_valid && rdy) begin
         e_valid = 0;
      end
      if (rej1 && e_rej < 255) e_rej++;
      p2_has = p1_has; p2_avg = p1_avg; p2_cls = p1_cls;
`ifdef HR_MON_REJECT_CNT_EN
      acc = v && (d >= 32'(MIN_BPM)) && (d <= 32'(MAX_BPM));
      rej = v && !acc;
      val = acc ? int'(d) : 0;
`else
      acc = v;
      rej = 0;
      val = (d > 32'd255) ? 255 : int'(d);
`endif
      if (acc) model_sample(val, p1_has, p1_avg, p1_cls);
      else p1_has = 0;
      rej1 = rej;
   endtask

   task automatic compare_all();
      check("avg_valid",  avg_valid,  e_valid);
      check("avg_bpm",    avg_bpm,    e_avg);
      check("hr_class",   hr_class,   e_cls);
      check("alarm",      alarm,      e_alarm);
      check("overrun",    overrun,    e_ovr);
      check("reject_cnt", reject_cnt, e_rej);
   endtask

   // Called at a falling edge: drive, let one rising edge pass, compare at the next falling edge.
   task automatic step(input logic r, input logic v, input logic [31:0] d, input logic rdy);
      rst = r; bpm_valid = v; bpm_in = d; avg_ready = rdy;
      model_edge(r, v, d, rdy);
      @(negedge clk);
      compare_all();
   endtask

   task automatic strobe(input int val, input logic rdy = 1'b1);
      step(1'b1, 1'b1, 32'(val), rdy);
   endtask

   task automatic idle(input int n, input logic rdy = 1'b1);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, rdy);
   endtask

   int bases[6] = '{45, 58, 72, 97, 120, 180};

   initial begin
      int base, sel;
      logic r, v, rdy;
      logic [31:0] d;

      rst = 1'b0; bpm_valid = 1'b0; bpm_in = '0; avg_ready = 1'b1;
      model_reset();
      @(negedge clk);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      check("reset_class", hr_class, C_UNKNOWN);

      // Fill and normal
      for (int i = 0; i < 4; i++) strobe(72);
      idle(2);
      check("fill_valid", avg_valid, 1);
      check("fill_avg",   avg_bpm,   72);
      check("fill_class", hr_class,  C_NORMAL);

      // Brady confirmation on the fourth average
      for (int i = 0; i < 4; i++) strobe(40);
      idle(2);
      check("brady_class", hr_class, C_BRADY);
      check("brady_alarm", alarm,    1);
      check("brady_avg",   avg_bpm,  40);

      // Hysteresis exit
      for (int i = 0; i < 4; i++) strobe(62);
      idle(2);
      check("hyst_hold", hr_class, C_BRADY);
      for (int i = 0; i < 5; i++) strobe(66);
      idle(2);
      check("hyst_exit", hr_class, C_NORMAL);
      check("hyst_avg",  avg_bpm,  66);

      // Out-of-range samples
      strobe(250);
      strobe(10);
      idle(2);
`ifdef HR_MON_REJECT_CNT_EN
      check("rej_cnt", reject_cnt, 2);
      check("rej_avg", avg_bpm,    66);
`else
      check("rej_cnt", reject_cnt, 0);
      check("rej_avg", avg_bpm,    98);
`endif

      // Backpressure and overrun
      strobe(80, 1'b0);
      strobe(80, 1'b0);
      idle(2, 1'b0);
      check("bp_valid",   avg_valid, 1);
      check("bp_overrun", overrun,   1);
`ifdef HR_MON_REJECT_CNT_EN
      check("bp_avg", avg_bpm, 73);
`else
      check("bp_avg", avg_bpm, 105);
`endif
      idle(1, 1'b1);
      check("bp_drop", avg_valid, 0);

      // Tachy then a one-cycle reset mid-run
      for (int i = 0; i < 4; i++) strobe(130);
      idle(2);
      step(1'b0, 1'b0, 32'd0, 1'b1);
      check("mrst_valid",   avg_valid,  0);
      check("mrst_avg",     avg_bpm,    0);
      check("mrst_class",   hr_class,   C_UNKNOWN);
      check("mrst_alarm",   alarm,      0);
      check("mrst_overrun", overrun,    0);
      check("mrst_rej",     reject_cnt, 0);
      for (int i = 0; i < 3; i++) strobe(130);
      idle(2);
      check("mrst_nofill", avg_valid, 0);

      // Randomized traffic around drifting base rates
      base = 72;
      for (int c = 0; c < 4000; c++) begin
         if (c % 50 == 0) base = bases[$urandom_range(0, 5)];
         r   = ($urandom_range(0, 299) != 0);
         v   = ($urandom_range(0, 2) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         sel = int'($urandom_range(0, 19));
         if (sel == 0)      d = $urandom();
         else if (sel == 1) d = $urandom_range(0, 40);
         else               d = 32'(base - 8 + int'($urandom_range(0, 16)));
         step(r, v, d, rdy);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
